// File: rtl/sign_frame_ctrl.sv
// Frame sequencer for the byte sign-detect datapath: classifies accepted samples
// as negative/zero/positive, counts each class over FRAME_LEN samples and holds a report.
module sign_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    rpt_valid,
  input  logic                    rpt_ack,
  output logic [CNT_W-1:0]        neg_cnt,
  output logic [CNT_W-1:0]        zero_cnt,
  output logic [CNT_W-1:0]        pos_cnt,
  output logic                    last_sign,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_NEG  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_POS  = 2'd2
  } cls_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] neg_q, neg_d;
  logic [CNT_W-1:0] zero_q, zero_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             last_sign_q, last_sign_d;
  logic             accept;
  cls_t             cls;

  function automatic cls_t classify(input logic signed [WIDTH-1:0] s);
    if (s[WIDTH-1]) begin
      return CLS_NEG;
    end else if (s == '0) begin
      return CLS_ZERO;
    end else begin
      return CLS_POS;
    end
  endfunction

  assign accept = in_valid && in_ready;
  assign cls    = classify(in_data);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && (idx_q == LAST_IDX)) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (rpt_ack) state_d = start ? S_ACCUM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: only in_ready sees a live input (abort)
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    rpt_valid = 1'b0;
    case (state_q)
      S_ACCUM: begin
        in_ready = !abort;
        busy     = 1'b1;
      end
      S_REPORT: begin
        rpt_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter/index next values; a new frame or an abort wipes the statistics
  always_comb begin
    neg_d       = neg_q;
    zero_d      = zero_q;
    pos_d       = pos_q;
    idx_d       = idx_q;
    last_sign_d = last_sign_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d       = '0;
          zero_d      = '0;
          pos_d       = '0;
          idx_d       = '0;
          last_sign_d = 1'b0;
        end
      end
      S_ACCUM: begin
        if (abort) begin
          neg_d       = '0;
          zero_d      = '0;
          pos_d       = '0;
          idx_d       = '0;
          last_sign_d = 1'b0;
        end else if (accept) begin
          idx_d       = idx_q + CNT_ONE;
          last_sign_d = in_data[WIDTH-1];
          case (cls)
            CLS_NEG:  neg_d  = neg_q + CNT_ONE;
            CLS_ZERO: zero_d = zero_q + CNT_ONE;
            default:  pos_d  = pos_q + CNT_ONE;
          endcase
        end
      end
      S_REPORT: begin
        if (rpt_ack && start) begin
          neg_d       = '0;
          zero_d      = '0;
          pos_d       = '0;
          idx_d       = '0;
          last_sign_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q       <= '0;
      zero_q      <= '0;
      pos_q       <= '0;
      idx_q       <= '0;
      last_sign_q <= 1'b0;
    end else begin
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      pos_q       <= pos_d;
      idx_q       <= idx_d;
      last_sign_q <= last_sign_d;
    end
  end

  assign neg_cnt   = neg_q;
  assign zero_cnt  = zero_q;
  assign pos_cnt   = pos_q;
  assign last_sign = last_sign_q;

endmodule

// File: tb/tb_sign_frame_ctrl.sv
// Directed bench for sign_frame_ctrl: default FRAME_LEN=4 instance plus a FRAME_LEN=1 instance.
module tb_sign_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, abort, in_valid, rpt_ack;
  logic [7:0] in_data;
  logic       in_ready, rpt_valid, last_sign, busy;
  logic [2:0] neg_cnt, zero_cnt, pos_cnt;

  logic       start1, abort1, in_valid1, rpt_ack1;
  logic [7:0] in_data1;
  logic       in_ready1, rpt_valid1, last_sign1, busy1;
  logic [0:0] neg1, zero1, pos1;

  int n_checks = 0;
  int n_fail   = 0;

  sign_frame_ctrl #(.WIDTH(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rpt_valid(rpt_valid), .rpt_ack(rpt_ack),
    .neg_cnt(neg_cnt), .zero_cnt(zero_cnt), .pos_cnt(pos_cnt),
    .last_sign(last_sign), .busy(busy)
  );

  sign_frame_ctrl #(.WIDTH(8), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .rpt_valid(rpt_valid1), .rpt_ack(rpt_ack1),
    .neg_cnt(neg1), .zero_cnt(zero1), .pos_cnt(pos1),
    .last_sign(last_sign1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; rpt_ack = 0; in_data = 8'h00;
    start1 = 0; abort1 = 0; in_valid1 = 0; rpt_ack1 = 0; in_data1 = 8'h00;
    #2;
    n_checks++;
    if ({in_ready, rpt_valid, busy, last_sign, neg_cnt, zero_cnt, pos_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b busy=%b ls=%b n=%0d z=%0d p=%0d, want all 0",
               in_ready, rpt_valid, busy, last_sign, neg_cnt, zero_cnt, pos_cnt);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [4] = '{8'b00001111, 8'b11010000, 8'b01110001, 8'b11111111};
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accum_entry: got busy=%b rdy=%b, want 1 1", busy, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
      if (i == 2) begin
        n_checks++;
        if (rpt_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_early_report: got rpt_valid=%b after 3 accepts, want 0", rpt_valid);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (rpt_valid !== 1'b1 || neg_cnt !== 3'd2 || zero_cnt !== 3'd0 || pos_cnt !== 3'd2 || last_sign !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_report: got rv=%b n=%0d z=%0d p=%0d ls=%b, want rv=1 n=2 z=0 p=2 ls=1",
               rpt_valid, neg_cnt, zero_cnt, pos_cnt, last_sign);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] v [4] = '{8'h00, 8'h80, 8'h00, 8'h7F};
    rpt_ack = 1'b1;
    tick();
    rpt_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
      if (i < 3) begin
        in_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          tick();
          n_checks++;
          if (in_ready !== 1'b1 || rpt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_ready: sample %0d gap %0d got rdy=%b rv=%b, want 1 0", i, g, in_ready, rpt_valid);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (rpt_valid !== 1'b1 || neg_cnt !== 3'd1 || zero_cnt !== 3'd2 || pos_cnt !== 3'd1 || last_sign !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_report: got rv=%b n=%0d z=%0d p=%0d ls=%b, want rv=1 n=1 z=2 p=1 ls=0",
               rpt_valid, neg_cnt, zero_cnt, pos_cnt, last_sign);
    end
  endtask

  task automatic test_report_hold();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    start    = 1'b1;
    abort    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || rpt_valid !== 1'b1 || busy !== 1'b1 ||
          neg_cnt !== 3'd1 || zero_cnt !== 3'd2 || pos_cnt !== 3'd1 || last_sign !== 1'b0) begin
        n_fail++;
        $display("FAIL report_hold: cycle %0d got rdy=%b rv=%b busy=%b n=%0d z=%0d p=%0d ls=%b, want 0 1 1 1 2 1 0",
                 i, in_ready, rpt_valid, busy, neg_cnt, zero_cnt, pos_cnt, last_sign);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    rpt_ack = 1'b1;
    tick();
    rpt_ack = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rpt_valid !== 1'b0 || neg_cnt !== 3'd1 || zero_cnt !== 3'd2 || pos_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL report_ack: got busy=%b rv=%b n=%0d z=%0d p=%0d, want 0 0 1 2 1",
               busy, rpt_valid, neg_cnt, zero_cnt, pos_cnt);
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h90;
    tick();
    in_data = 8'h10;
    tick();
    n_checks++;
    if (neg_cnt !== 3'd1 || pos_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL abort_pre: got n=%0d p=%0d, want 1 1", neg_cnt, pos_cnt);
    end
    in_data = 8'hFF;
    abort = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: got rdy=%b with abort high, want 0", in_ready);
    end
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rpt_valid !== 1'b0 || neg_cnt !== 3'd0 || zero_cnt !== 3'd0 || pos_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b rv=%b n=%0d z=%0d p=%0d, want 0 0 0 0 0",
               busy, rpt_valid, neg_cnt, zero_cnt, pos_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    n_checks++;
    if (rpt_valid !== 1'b1 || pos_cnt !== 3'd4 || neg_cnt !== 3'd0 || zero_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_restart: got rv=%b n=%0d z=%0d p=%0d, want 1 0 0 4",
               rpt_valid, neg_cnt, zero_cnt, pos_cnt);
    end
  endtask

  task automatic test_ack_start();
    rpt_ack = 1'b1;
    start = 1'b1;
    tick();
    rpt_ack = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rpt_valid !== 1'b0 || in_ready !== 1'b1 ||
        neg_cnt !== 3'd0 || zero_cnt !== 3'd0 || pos_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL ack_start: got busy=%b rv=%b rdy=%b n=%0d z=%0d p=%0d, want 1 0 1 0 0 0",
               busy, rpt_valid, in_ready, neg_cnt, zero_cnt, pos_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v [3] = '{8'h80, 8'h00, 8'h05};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = v[i];
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (neg_cnt !== 3'd1 || zero_cnt !== 3'd1 || pos_cnt !== 3'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got n=%0d z=%0d p=%0d busy=%b, want 1 1 1 1", neg_cnt, zero_cnt, pos_cnt, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, rpt_valid, busy, last_sign, neg_cnt, zero_cnt, pos_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL areset_async: got rdy=%b rv=%b busy=%b ls=%b n=%0d z=%0d p=%0d, want all 0",
               in_ready, rpt_valid, busy, last_sign, neg_cnt, zero_cnt, pos_cnt);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || pos_cnt !== 3'd0 || rpt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_nostart: got busy=%b rdy=%b p=%0d rv=%b, want 0 0 0 0", busy, in_ready, pos_cnt, rpt_valid);
    end
  endtask

  task automatic test_frame_len1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    in_valid1 = 1'b1;
    in_data1 = 8'h00;
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL len1_ready: got rdy=%b, want 1", in_ready1);
    end
    tick();
    in_valid1 = 1'b0;
    n_checks++;
    if (rpt_valid1 !== 1'b1 || zero1 !== 1'b1 || neg1 !== 1'b0 || pos1 !== 1'b0 || in_ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_report: got rv=%b n=%0d z=%0d p=%0d rdy=%b, want 1 0 1 0 0",
               rpt_valid1, neg1, zero1, pos1, in_ready1);
    end
    rpt_ack1 = 1'b1;
    start1 = 1'b1;
    tick();
    rpt_ack1 = 1'b0;
    start1 = 1'b0;
    in_valid1 = 1'b1;
    in_data1 = 8'hC3;
    tick();
    in_valid1 = 1'b0;
    n_checks++;
    if (rpt_valid1 !== 1'b1 || neg1 !== 1'b1 || zero1 !== 1'b0 || last_sign1 !== 1'b1) begin
      n_fail++;
      $display("FAIL len1_neg: got rv=%b n=%0d z=%0d ls=%b, want 1 1 0 1", rpt_valid1, neg1, zero1, last_sign1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_report_hold();
    test_abort();
    test_ack_start();
    test_async_reset();
    test_frame_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
